// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op codes and FSM state type shared by the multiply/divide unit.
package mult_div_unit_pkg;
    typedef enum logic [3:0] {
        MDU_DUM   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MADD  = 4'd5,
        MDU_MADDU = 4'd6,
        MDU_MSUB  = 4'd7,
        MDU_MSUBU = 4'd8
    } mduOp_e;

    typedef enum logic {IDLE, BUSY} mduState_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/DIV unit with HI/LO registers, MTHI/MTLO and MFHI/MFLO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [1:0]  mthilo,
    input  logic [1:0]  mfhilo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] result
);
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
`ifdef MDU_MADD_EN
    localparam logic [3:0] LAST_OP = MDU_MSUBU;
`else
    localparam logic [3:0] LAST_OP = MDU_DIVU;
`endif

    mduState_e   state;
    logic [CW-1:0] counter;
    logic [63:0] pending, nextPending, sProd, uProd, hiLo;
    logic [31:0] sQuo, sRem, uQuo, uRem;
    logic        validOp, isDiv;

    assign hiLo    = {hi, lo};
    assign validOp = mdu_op != MDU_DUM && mdu_op <= LAST_OP;
    assign isDiv   = mdu_op == MDU_DIV || mdu_op == MDU_DIVU;
    assign busy    = state == BUSY;
    assign start   = validOp & ~busy & ~flush;
    assign stall_req = start | busy;
    assign result  = mfhilo[1] ? hi : mfhilo[0] ? lo : '0;

    assign sProd = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign uProd = {32'b0, rs_val} * {32'b0, rt_val};
    // Division by zero is masked below, so the quotient value there is irrelevant.
    assign sQuo  = $signed(rs_val) / $signed(rt_val);
    assign sRem  = $signed(rs_val) % $signed(rt_val);
    assign uQuo  = rs_val / rt_val;
    assign uRem  = rs_val % rt_val;

    always_comb begin
        nextPending = hiLo;
        case (mdu_op)
            MDU_MULT:  nextPending = sProd;
            MDU_MULTU: nextPending = uProd;
            MDU_DIV:   nextPending = rt_val != 0 ? {sRem, sQuo} : hiLo;
            MDU_DIVU:  nextPending = rt_val != 0 ? {uRem, uQuo} : hiLo;
`ifdef MDU_MADD_EN
            MDU_MADD:  nextPending = hiLo + sProd;
            MDU_MADDU: nextPending = hiLo + uProd;
            MDU_MSUB:  nextPending = hiLo - sProd;
            MDU_MSUBU: nextPending = hiLo - uProd;
`endif
            default:   nextPending = hiLo;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending <= nextPending;
                        counter <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state   <= BUSY;
                    end else if (mthilo != 2'b00 && !flush) begin
                        if (mthilo[1]) hi <= rs_val;
                        if (mthilo[0]) lo <= rs_val;
                    end
                end
                BUSY: begin
                    if (counter == CW'(1)) begin
                        {hi, lo} <= pending;
                        counter  <= '0;
                        state    <= IDLE;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed HI/LO expectations.
// Build with MDU_MADD_EN defined to also exercise the accumulate ops.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 0, reset = 1, flush = 0;
    logic [3:0]  mdu_op = MDU_DUM;
    logic [1:0]  mthilo = 0, mfhilo = 0;
    logic [31:0] rs_val = 0, rt_val = 0;
    logic        start, busy, stall_req;
    logic [31:0] hi, lo, result;
    int nCompared = 0, nMismatched = 0;

    mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .mdu_op(mdu_op), .mthilo(mthilo), .mfhilo(mfhilo),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .start(start), .busy(busy),
        .stall_req(stall_req), .hi(hi), .lo(lo), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents an op for one cycle; returns at the falling edge of the first busy cycle.
    task automatic startOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu_op = op; rs_val = a; rt_val = b;
        #1 check("start", {31'b0, start}, 1);
        @(negedge clk);
        mdu_op = MDU_DUM;
        check("busy_first", {31'b0, busy}, 1);
    endtask

    task automatic waitDone(input string tag, input int k);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, k);
    endtask

    task automatic writeHiLo(input logic [1:0] sel, input logic [31:0] v);
        @(negedge clk);
        mthilo = sel; rs_val = v;
        @(negedge clk);
        mthilo = 0;
    endtask

    initial begin
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_stall", {31'b0, stall_req}, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        startOp(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_stall", {31'b0, stall_req}, 1);
        waitDone("mult_lat", MULT_CYCLES);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        startOp(MDU_DIVU, 32'd100, 32'd7);
        waitDone("divu_lat", DIV_CYCLES);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        startOp(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone("div_lat", DIV_CYCLES);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        writeHiLo(2'b10, 32'd5);
        writeHiLo(2'b01, 32'd9);
        check("mthi", hi, 32'd5);
        check("mtlo", lo, 32'd9);
        startOp(MDU_DIV, 32'd123, 32'd0);
        waitDone("div0_lat", DIV_CYCLES);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'd9);

        writeHiLo(2'b01, 32'h1234);
        mfhilo = 2'b01;
        #1 check("mflo", result, 32'h1234);
        mfhilo = 2'b00;
        #1 check("mf_none", result, 0);

        // MTHI, a second op, flush and MFHI all land while MULTU is in flight.
        startOp(MDU_MULTU, 32'd2, 32'd3);
        mthilo = 2'b10; rs_val = 32'hDEAD; mdu_op = MDU_DIVU; rt_val = 1; flush = 1; mfhilo = 2'b10;
        #1 check("mfhi_busy", result, 32'd5);
        check("stall_busy", {31'b0, stall_req}, 1);
        check("start_busy", {31'b0, start}, 0);
        @(negedge clk);
        mthilo = 0; mdu_op = MDU_DUM; flush = 0; mfhilo = 0;
        check("mthi_busy", hi, 32'd5);
        waitDone("multu_lat", MULT_CYCLES - 1);
        check("multu_hi", hi, 0);
        check("multu_lo", lo, 32'd6);
        @(negedge clk);
        check("no_queued_op", {31'b0, busy}, 0);

        startOp(MDU_MULT, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        reset = 1;
        #1 check("rmid_busy", {31'b0, busy}, 0);
        check("rmid_lo", lo, 0);
        check("rmid_hi", hi, 0);
        #2 reset = 0;
        repeat (10) @(negedge clk);
        check("rmid_no_commit", lo, 0);

        @(negedge clk);
        mdu_op = MDU_MULT; rs_val = 32'd3; rt_val = 32'd4; flush = 1;
        #1 check("flush_start", {31'b0, start}, 0);
        check("flush_stall", {31'b0, stall_req}, 0);
        @(negedge clk);
        mdu_op = MDU_DUM; flush = 0;
        check("flush_busy", {31'b0, busy}, 0);
        check("flush_lo", lo, 0);

        @(negedge clk);
        mdu_op = 4'hF;
        #1 check("unknown_op", {31'b0, start}, 0);
`ifndef MDU_MADD_EN
        mdu_op = MDU_MADDU;
        #1 check("madd_disabled", {31'b0, start}, 0);
`endif
        @(negedge clk);
        mdu_op = MDU_DUM;

`ifdef MDU_MADD_EN
        writeHiLo(2'b01, 32'hFFFF_FFFF);
        startOp(MDU_MADDU, 32'd1, 32'd1);
        waitDone("maddu_lat", MULT_CYCLES);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
